// File: rtl/shift_rows_stream.sv
// Streaming Rijndael ShiftRows/InvShiftRows for Nb = 4/6/8 with an output FIFO.
// Optional transfer/stall counters: define SHIFT_ROWS_STREAM_STATS_EN.
module shift_rows_stream #(
    parameter int NB         = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_inv,
    input  logic [32*NB-1:0] in_state,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*NB-1:0] out_state,
    output logic            out_inv
`ifdef SHIFT_ROWS_STREAM_STATS_EN
    ,
    output logic [31:0]     xfer_count,
    output logic [15:0]     stall_count
`endif
);

    localparam int W  = 32 * NB;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("shift_rows_stream: FIFO_DEPTH must be a power of 2, >= 2");
    end

    // The 256-bit block shifts rows 2 and 3 one column further than narrower blocks.
    function automatic int row_off(input int r);
        if (NB == 8 && r >= 2)
            return r + 1;
        return r;
    endfunction

    function automatic logic [W-1:0] shift_rows(
        input logic [W-1:0] s,
        input logic         inv
    );
        logic [W-1:0] t;
        int           src;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                if (inv)
                    src = (c - row_off(r) + NB) % NB;
                else
                    src = (c + row_off(r)) % NB;
                t[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src+r) -: 8];
            end
        end
        return t;
    endfunction

    logic [W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [W:0]    head;
    logic [W-1:0]  shifted;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign shifted   = shift_rows(in_state, in_inv);
    assign head      = mem[rd_ptr];

    // Storage is left uncleared; the empty head is masked instead.
    assign out_state = out_valid ? head[W-1:0] : '0;
    assign out_inv   = out_valid & head[W];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_inv, shifted};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SHIFT_ROWS_STREAM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop)
                xfer_count <= xfer_count + 32'd1;
            if (in_valid && !in_ready && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`else
    // No statistics counters in this build; datapath is unchanged.
`endif

endmodule

// File: tb/tb_shift_rows_stream.sv
// Randomized self-checking bench for shift_rows_stream (directed NB=4 cases
// plus forward->inverse round-trip chains for NB = 4, 6, 8).
module tb_shift_rows_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: each row held as a list of bytes and rotated as a list.
    function automatic logic [255:0] ref_shift(input logic [255:0] s,
                                               input int nb, input bit inv);
        logic [7:0]   b [32];
        logic [7:0]   row [$];
        logic [255:0] r;
        int           off;
        for (int k = 0; k < 4 * nb; k++)
            b[k] = s[32*nb-1-8*k -: 8];
        for (int rr = 0; rr < 4; rr++) begin
            off = (nb == 8 && rr >= 2) ? rr + 1 : rr;
            row.delete();
            for (int c = 0; c < nb; c++)
                row.push_back(b[4*c+rr]);
            repeat (off) begin
                if (!inv)
                    row.push_back(row.pop_front());
                else
                    row.push_front(row.pop_back());
            end
            for (int c = 0; c < nb; c++)
                b[4*c+rr] = row[c];
        end
        r = '0;
        for (int k = 0; k < 4 * nb; k++)
            r[32*nb-1-8*k -: 8] = b[k];
        return r;
    endfunction

    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_inv;
`ifdef SHIFT_ROWS_STREAM_STATS_EN
    logic [31:0]  xfer_count;
    logic [15:0]  stall_count;
`endif

    shift_rows_stream #(.NB(4), .FIFO_DEPTH(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_inv   (out_inv)
`ifdef SHIFT_ROWS_STREAM_STATS_EN
        ,
        .xfer_count  (xfer_count),
        .stall_count (stall_count)
`endif
    );

    bit        start = 1'b0;
    wire [2:0] done;

    for (genvar g = 0; g < 3; g++) begin : g_chain
        localparam int N  = 4 + 2 * g;
        localparam int CW = 32 * N;
        localparam int NUM = 500;

        logic          a_iv, a_ir, a_ii, a_ov, a_oi;
        logic          b_ir, b_ov, b_or, b_oi;
        logic [CW-1:0] a_is, a_os, b_os;
`ifdef SHIFT_ROWS_STREAM_STATS_EN
        logic [31:0]   a_xc, b_xc;
        logic [15:0]   a_sc, b_sc;
`endif
        logic [255:0]  qa [$];
        logic [255:0]  qb [$];
        bit            qai [$];
        bit            qbi [$];
        int            got_n = 0;

        assign done[g] = (got_n >= NUM);

        shift_rows_stream #(.NB(N), .FIFO_DEPTH(2)) u_fwd (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (a_iv),
            .in_ready  (a_ir),
            .in_inv    (a_ii),
            .in_state  (a_is),
            .out_valid (a_ov),
            .out_ready (b_ir),
            .out_state (a_os),
            .out_inv   (a_oi)
`ifdef SHIFT_ROWS_STREAM_STATS_EN
            ,
            .xfer_count  (a_xc),
            .stall_count (a_sc)
`endif
        );

        shift_rows_stream #(.NB(N), .FIFO_DEPTH(4)) u_inv (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (a_ov),
            .in_ready  (b_ir),
            .in_inv    (~a_oi),
            .in_state  (a_os),
            .out_valid (b_ov),
            .out_ready (b_or),
            .out_state (b_os),
            .out_inv   (b_oi)
`ifdef SHIFT_ROWS_STREAM_STATS_EN
            ,
            .xfer_count  (b_xc),
            .stall_count (b_sc)
`endif
        );

        initial begin
            int  sent;
            bit  acc;
            logic [255:0] v;
            a_iv = 1'b0;
            a_ii = 1'b0;
            a_is = '0;
            b_or = 1'b0;
            sent = 0;
            wait (start);
            for (int cyc = 0; cyc < 20000 && sent < NUM; cyc++) begin
                @(negedge clk);
                acc = a_iv && a_ir;
                @(posedge clk);
                #1;
                if (acc)
                    sent++;
                b_or = ($urandom_range(0, 3) != 0);
                if (!a_iv || acc) begin
                    if (sent < NUM && $urandom_range(0, 4) != 0) begin
                        a_is = CW'(rand256());
                        a_ii = 1'($urandom());
                        a_iv = 1'b1;
                        v = 256'(a_is);
                        qa.push_back(ref_shift(v, N, a_ii));
                        qai.push_back(a_ii);
                        qb.push_back(v);
                        qbi.push_back(!a_ii);
                    end else begin
                        a_iv = 1'b0;
                    end
                end
            end
            a_iv = 1'b0;
            b_or = 1'b1;
        end

        always @(negedge clk) begin
            if (a_ov && b_ir) begin
                check($sformatf("fwd%0d_has_exp", N), 256'(qa.size() > 0), 256'(1));
                if (qa.size() > 0) begin
                    check($sformatf("fwd%0d_state", N), 256'(a_os), qa.pop_front());
                    check($sformatf("fwd%0d_inv", N), 256'(a_oi), 256'(qai.pop_front()));
                end
            end
            if (b_ov && b_or) begin
                check($sformatf("rt%0d_has_exp", N), 256'(qb.size() > 0), 256'(1));
                if (qb.size() > 0) begin
                    check($sformatf("rt%0d_state", N), 256'(b_os), qb.pop_front());
                    check($sformatf("rt%0d_inv", N), 256'(b_oi), 256'(qbi.pop_front()));
                end
                got_n++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] k_plain;
    logic [127:0] k_shift;
    logic [127:0] x [3];
    logic [255:0] exp_q [$];
    bit           exp_i [$];

    initial begin
        k_plain   = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
        k_shift   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_state", 256'(out_state), 256'(0));
        check("rst_out_inv", 256'(out_inv), 256'(0));
        rst_n = 1'b1;

        // Known-answer forward and inverse
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_state  = k_plain;
        tick();
        in_valid = 1'b0;
        check("fwd_valid", 256'(out_valid), 256'(1));
        check("fwd_state", 256'(out_state), 256'(k_shift));
        check("fwd_model", 256'(out_state), ref_shift(256'(k_plain), 4, 1'b0));
        check("fwd_inv", 256'(out_inv), 256'(0));
        tick();
        check("fwd_drained", 256'(out_valid), 256'(0));
        in_valid = 1'b1;
        in_inv   = 1'b1;
        in_state = k_shift;
        tick();
        in_valid = 1'b0;
        check("inv_state", 256'(out_state), 256'(k_plain));
        check("inv_inv", 256'(out_inv), 256'(1));
        tick();

        // Back-pressure with a 2-deep FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            x[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_inv   = 1'b0;
        in_valid = 1'b1;
        in_state = x[0];
        tick();
        in_state = x[1];
        tick();
        check("bp_full_ready", 256'(in_ready), 256'(0));
        check("bp_head", 256'(out_state), ref_shift(256'(x[0]), 4, 1'b0));
        in_state = x[2];
        tick();
        check("bp_still_full", 256'(in_ready), 256'(0));
        check("bp_hold", 256'(out_state), ref_shift(256'(x[0]), 4, 1'b0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ready_back", 256'(in_ready), 256'(1));
        check("bp_second", 256'(out_state), ref_shift(256'(x[1]), 4, 1'b0));
        tick();
        in_valid = 1'b0;
        check("bp_refull", 256'(in_ready), 256'(0));
        out_ready = 1'b1;
        tick();
        check("bp_third", 256'(out_state), ref_shift(256'(x[2]), 4, 1'b0));
        tick();
        check("bp_empty", 256'(out_valid), 256'(0));

        // Full-rate streaming, 100 states
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_inv   = 1'($urandom());
            exp_q.push_back(ref_shift(256'(in_state), 4, in_inv));
            exp_i.push_back(in_inv);
            tick();
            check("stream_ready", 256'(in_ready), 256'(1));
            check("stream_valid", 256'(out_valid), 256'(1));
            check("stream_state", 256'(out_state), exp_q.pop_front());
            check("stream_inv", 256'(out_inv), 256'(exp_i.pop_front()));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end", 256'(out_valid), 256'(0));

        // Reset with two states buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inv    = 1'b1;
        in_state  = k_shift;
        tick();
        in_state = k_plain;
        tick();
        in_valid = 1'b0;
        check("mid_buffered", 256'(out_valid), 256'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 256'(out_valid), 256'(0));
        check("mid_rst_ready", 256'(in_ready), 256'(1));
        check("mid_rst_state", 256'(out_state), 256'(0));
        check("mid_rst_inv", 256'(out_inv), 256'(0));
`ifdef SHIFT_ROWS_STREAM_STATS_EN
        check("mid_rst_xfer", 256'(xfer_count), 256'(0));
        check("mid_rst_stall", 256'(stall_count), 256'(0));
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_stale", 256'(out_valid), 256'(0));
        end

        // Round-trip chains for NB = 4, 6, 8
        start = 1'b1;
        for (int i = 0; i < 30000 && done != 3'b111; i++)
            @(posedge clk);
        check("chains_done", 256'(done), 256'(3'b111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Parametrised, pipelined successor to the combinational ShiftRows stage.
- Supports Rijndael block widths Nb = 4/6/8 columns (128/192/256-bit state).
- Per-transaction mode select: forward ShiftRows or InvShiftRows.
- Valid/ready streaming with an internal output FIFO. Sits between SubBytes and MixColumns in the iterative cipher/decipher datapath.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error.
- FIFO_DEPTH, 2, output buffer entries; power of 2, ≥ 2.
- W, 32*NB, derived state width (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input state valid
- in_ready  out  1  block can accept a state this cycle
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the input state
- in_state  in  W  input state
- out_valid  out  1  head of FIFO valid
- out_ready  in  1  downstream accepts
- out_state  out  W  transformed state
- out_inv  out  1  mode echoed alongside the result

Behaviour:
- **Byte map:**
  - byte k = in_state[W-1-8k -: 8], so byte 0 is the MSB.
  - s[r][c] = byte 4c+r, with r in 0..3 and c in 0..NB-1 (column-major).
- **Row offsets C_r:**
  - NB = 4 or 6: (0, 1, 2, 3).
  - NB = 8: (0, 1, 3, 4).
- **Forward:** s'[r][c] = s[r][(c + C_r) mod NB].
- **Inverse:** s'[r][c] = s[r][(c - C_r + NB) mod NB].
- **Transfer rules:**
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- **Datapath:**
  - The transform is combinational on in_state.
  - The result and in_inv are written into the FIFO tail on the input-transfer edge.
- **Latency:** a state accepted at edge N appears on out_state with out_valid = 1 after edge N. This is 1 cycle minimum; there is no combinational in→out path.
- **FIFO:**
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Occupancy count is log2(FIFO_DEPTH)+1 bits.
  - out_valid = (count != 0).
  - in_ready = (count != FIFO_DEPTH). It is registered-state-derived and does not depend on out_ready.
- **Simultaneous push and pop:**
  - With 0 < count < FIFO_DEPTH: count unchanged, both pointers advance.
  - When full: no push is possible (in_ready = 0), pop proceeds, and in_ready rises the next cycle.
  - When empty: no pop is possible, push proceeds.
- **Ordering:** strict FIFO order; each result stays paired with its out_inv.
- **Holding:**
  - out_state and out_inv hold stable while out_valid && !out_ready.
  - in_valid deasserted: no FIFO write, regardless of in_state value.
- **Reset** (rst_n low at a clock edge):
  - pointers = 0, count = 0, out_valid = 0, in_ready = 1 in the cycle after reset.
  - out_state = 0 and out_inv = 0; FIFO storage is not cleared, but the head is masked to 0 when empty.
  - Reset mid-stream discards all buffered states; no partial output.
- No state machine beyond the FIFO counters; throughput is 1 state/cycle when out_ready is held high.

Optional Feature:
- Macro: SHIFT_ROWS_STREAM_STATS_EN.
- **Defined:**
  - Adds output port xfer_count [31:0]: count of output transfers since reset. It increments by 1 per out_valid && out_ready edge, wraps 0xFFFFFFFF→0, and resets to 0.
  - Adds output port stall_count [15:0]: cycles with in_valid && !in_ready. It saturates at 0xFFFF and resets to 0.
- **Undefined:** neither port exists; behaviour is otherwise identical.

Test Plan:
- **Forward, NB=4, out_ready=1:** in_state = d42711ae_e0bf98f1_b8b45de5_1e415230 → one cycle later out_state = d4bf5d30_e0b452ae_b84111f1_1e2798e5, out_inv=0.
- **Inverse, NB=4:** in_inv=1, in_state = d4bf5d30_e0b452ae_b84111f1_1e2798e5 → out_state = d42711ae_e0bf98f1_b8b45de5_1e415230, out_inv=1.
- **Round trip:** 500 random states with random in_inv, fed through a forward instance then an inverse instance. Run for NB = 4, 6 and 8 (NB=8 checks offsets 0/1/3/4) → every state is recovered bit-exact.
- **Back-pressure, FIFO_DEPTH=2:** hold out_ready=0 and push 3 states → first 2 accepted, in_ready=0 on the 3rd. Raise out_ready for 1 cycle → head pops, in_ready=1 the next cycle, order preserved.
- **Full-rate streaming:** in_valid=1 and out_ready=1 for 100 cycles → 100 outputs in order, in_ready never drops.
- **Reset mid-stream:** with 2 states buffered, drive rst_n=0 for 1 cycle → out_valid=0, in_ready=1, and no stale state emitted. With stats enabled, xfer_count=0 and stall_count=0.
